// File: rtl/sound_event_seq_pkg.sv
// Shared definitions for the sound event sequencer: event codes,
// note periods in clk10 cycles, FSM states and sequence lengths.
package sound_event_seq_pkg;

    // Event encoding, also the value driven on cur_event
    localparam logic [1:0] EV_WALL   = 2'd0;
    localparam logic [1:0] EV_PADDLE = 2'd1;
    localparam logic [1:0] EV_BRICK  = 2'd2;
    localparam logic [1:0] EV_LOSE   = 2'd3;

    // Full tone periods in clk10 cycles, named relative to do2
    localparam logic [15:0] NOTE_S    = 16'd0;      // silence
    localparam logic [15:0] NOTE_DO1  = 16'd34052;
    localparam logic [15:0] NOTE_FA1  = 16'd25510;
    localparam logic [15:0] NOTE_LA1  = 16'd20258;
    localparam logic [15:0] NOTE_DO2  = 16'd17026;
    localparam logic [15:0] NOTE_FA2  = 16'd12755;
    localparam logic [15:0] NOTE_SOL2 = 16'd11364;
    localparam logic [15:0] NOTE_DO3  = 16'd8513;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Number of notes in each event's sequence
    function automatic logic [2:0] seq_len(input logic [1:0] ev);
        logic [2:0] len;
        case (ev)
            EV_WALL:   len = 3'd1;
            EV_PADDLE: len = 3'd1;
            EV_BRICK:  len = 3'd2;
            default:   len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sound_event_seq_if.sv
// Tone-generator control bundle: the sequencer is the master,
// the square-wave generator is the slave.
interface sound_event_seq_if #(
    parameter int PW = 16
);
    logic          snd_en;
    logic [PW-1:0] note_period;
    logic          busy;
    logic [1:0]    cur_event;

    modport master (
        output snd_en,
        output note_period,
        output busy,
        output cur_event
    );

    modport slave (
        input snd_en,
        input note_period,
        input busy,
        input cur_event
    );
endinterface

// File: rtl/sound_note_rom.sv
// Combinational note table: (event, note index) -> period and last-note flag.
// All sequence content lives here.
module sound_note_rom
    import sound_event_seq_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic [1:0]    i_event,
    input  logic [1:0]    i_note_idx,
    output logic [PW-1:0] o_period,
    output logic          o_last
);

    logic [15:0] w_note;

    // Note lookup; unused index slots read as silence
    always_comb begin
        w_note = NOTE_S;
        case ({i_event, i_note_idx})
            {EV_WALL,   2'd0}: w_note = NOTE_DO2;
            {EV_PADDLE, 2'd0}: w_note = NOTE_FA2;
            {EV_BRICK,  2'd0}: w_note = NOTE_SOL2;
            {EV_BRICK,  2'd1}: w_note = NOTE_DO3;
            {EV_LOSE,   2'd0}: w_note = NOTE_DO2;
            {EV_LOSE,   2'd1}: w_note = NOTE_LA1;
            {EV_LOSE,   2'd2}: w_note = NOTE_FA1;
            {EV_LOSE,   2'd3}: w_note = NOTE_DO1;
            default:           w_note = NOTE_S;
        endcase
    end

    assign o_period = PW'(w_note);
    assign o_last   = ({1'b0, i_note_idx} == (seq_len(i_event) - 3'd1));

endmodule

// File: rtl/sound_event_seq.sv
// Sound event sequencer: latches one-cycle game event pulses, arbitrates
// lose > brick > paddle > wall, and plays each event's note sequence on
// the tone generator with fixed note and gap durations.
module sound_event_seq
    import sound_event_seq_pkg::*;
#(
    parameter int NOTE_TICKS = 1000000,
    parameter int GAP_TICKS  = 100000,
    parameter int PW         = 16
) (
    input  logic              clk10,
    input  logic              rst,
    input  logic              ev_wall,
    input  logic              ev_paddle,
    input  logic              ev_brick,
    input  logic              ev_lose,
    input  logic              mute,
    sound_event_seq_if.master snd
);

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_pend, w_pend_nxt;
    logic [TW-1:0] r_tick, w_tick_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [1:0]    r_cur, w_cur_nxt;
    logic [PW-1:0] r_period, w_period_nxt;

    logic [3:0]    w_set;
    logic [3:0]    w_clr;
    logic [1:0]    w_sel;
    logic          w_start;
    logic [1:0]    w_rom_ev;
    logic [1:0]    w_rom_idx;
    logic [PW-1:0] w_rom_period;
    logic          w_rom_last;

    assign w_set = {ev_lose, ev_brick, ev_paddle, ev_wall};

    // Highest-priority pending event
    always_comb begin
        w_sel = EV_WALL;
        if (r_pend[EV_LOSE])        w_sel = EV_LOSE;
        else if (r_pend[EV_BRICK])  w_sel = EV_BRICK;
        else if (r_pend[EV_PADDLE]) w_sel = EV_PADDLE;
    end

    // A sequence starts from IDLE on any pending event, or mid-sequence
    // when a lose event preempts a non-lose sequence.
    assign w_start = !mute &&
                     (((r_state == ST_IDLE) && (|r_pend)) ||
                      ((r_state != ST_IDLE) && r_pend[EV_LOSE] && (r_cur != EV_LOSE)));

    assign w_clr = w_start ? (4'b0001 << w_sel) : 4'b0000;

    // On a start the ROM reads note 0 of the selected event; otherwise it
    // reads the current event at the current index (last flag in PLAY,
    // next note in GAP since the index was already advanced).
    assign w_rom_ev  = w_start ? w_sel : r_cur;
    assign w_rom_idx = w_start ? 2'd0  : r_idx;

    sound_note_rom #(
        .PW (PW)
    ) u_rom (
        .i_event    (w_rom_ev),
        .i_note_idx (w_rom_idx),
        .o_period   (w_rom_period),
        .o_last     (w_rom_last)
    );

    // Next-state, counter and note-register logic
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick + TW'(1);
        w_idx_nxt    = r_idx;
        w_cur_nxt    = r_cur;
        w_period_nxt = r_period;
        w_pend_nxt   = mute ? 4'b0000 : ((r_pend & ~w_clr) | w_set);

        if (mute) begin
            w_state_nxt  = ST_IDLE;
            w_tick_nxt   = '0;
            w_idx_nxt    = 2'd0;
            w_period_nxt = '0;
        end else if (w_start) begin
            w_state_nxt  = ST_PLAY;
            w_tick_nxt   = '0;
            w_idx_nxt    = 2'd0;
            w_cur_nxt    = w_sel;
            w_period_nxt = w_rom_period;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_tick_nxt = '0;
                end
                ST_PLAY: begin
                    if (r_tick == NOTE_LAST) begin
                        w_tick_nxt = '0;
                        if (w_rom_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_GAP;
                            w_idx_nxt   = r_idx + 2'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_tick == GAP_LAST) begin
                        w_tick_nxt   = '0;
                        w_state_nxt  = ST_PLAY;
                        w_period_nxt = w_rom_period;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase
        end
    end

    // State, pending bits, counters and held note period
    always_ff @(posedge clk10) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pend   <= 4'b0000;
            r_tick   <= '0;
            r_idx    <= 2'd0;
            r_cur    <= EV_WALL;
            r_period <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_tick   <= w_tick_nxt;
            r_idx    <= w_idx_nxt;
            r_cur    <= w_cur_nxt;
            r_period <= w_period_nxt;
        end
    end

    assign snd.snd_en      = (r_state == ST_PLAY);
    assign snd.note_period = (r_state == ST_IDLE) ? '0 : r_period;
    assign snd.busy        = (r_state != ST_IDLE);
    assign snd.cur_event   = r_cur;

endmodule

// File: tb/tb_sound_event_seq.sv
// Directed bench for sound_event_seq with short note/gap timing.
// Expected per-cycle outputs are queued as each stimulus step is set up
// and compared one entry per clock.
module tb_sound_event_seq;

    localparam int NT = 20;
    localparam int GT = 5;
    localparam int PW = 16;

    logic clk10     = 1'b0;
    logic rst       = 1'b1;
    logic ev_wall   = 1'b0;
    logic ev_paddle = 1'b0;
    logic ev_brick  = 1'b0;
    logic ev_lose   = 1'b0;
    logic mute      = 1'b0;

    sound_event_seq_if #(.PW(PW)) snd ();

    sound_event_seq #(
        .NOTE_TICKS (NT),
        .GAP_TICKS  (GT),
        .PW         (PW)
    ) dut (
        .clk10     (clk10),
        .rst       (rst),
        .ev_wall   (ev_wall),
        .ev_paddle (ev_paddle),
        .ev_brick  (ev_brick),
        .ev_lose   (ev_lose),
        .mute      (mute),
        .snd       (snd)
    );

    always #5 clk10 = ~clk10;

    typedef struct packed {
        logic          en;
        logic [PW-1:0] per;
        logic          busy;
        logic [1:0]    cur;
    } obs_t;

    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string tag    = "init";

    task automatic expect_n(input int n, input logic en, input logic [PW-1:0] per,
                            input logic busy, input logic [1:0] cur);
        obs_t e;
        e.en   = en;
        e.per  = per;
        e.busy = busy;
        e.cur  = cur;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Full lose sequence: four notes with three gaps
    task automatic expect_lose();
        expect_n(NT, 1'b1, 16'd17026, 1'b1, 2'd3);
        expect_n(GT, 1'b0, 16'd17026, 1'b1, 2'd3);
        expect_n(NT, 1'b1, 16'd20258, 1'b1, 2'd3);
        expect_n(GT, 1'b0, 16'd20258, 1'b1, 2'd3);
        expect_n(NT, 1'b1, 16'd25510, 1'b1, 2'd3);
        expect_n(GT, 1'b0, 16'd25510, 1'b1, 2'd3);
        expect_n(NT, 1'b1, 16'd34052, 1'b1, 2'd3);
    endtask

    // Advance n clocks; after each edge drop the event pulses and compare
    // outputs against the next queued expectation.
    task automatic drain(input int n);
        obs_t e;
        obs_t o;
        for (int i = 0; i < n; i++) begin
            @(posedge clk10);
            #1;
            ev_wall   = 1'b0;
            ev_paddle = 1'b0;
            ev_brick  = 1'b0;
            ev_lose   = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s step %0d: observed output with no expectation queued", tag, i);
            end else begin
                e = exp_q.pop_front();
                o.en   = snd.snd_en;
                o.per  = snd.note_period;
                o.busy = snd.busy;
                o.cur  = snd.cur_event;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL %s step %0d: observed en=%b per=%0d busy=%b cur=%0d expected en=%b per=%0d busy=%b cur=%0d",
                           tag, i, o.en, o.per, o.busy, o.cur, e.en, e.per, e.busy, e.cur);
                end
            end
        end
    endtask

    initial begin
        // Reset state
        tag = "reset";
        expect_n(3, 1'b0, 16'd0, 1'b0, 2'd0);
        drain(3);
        rst = 1'b0;
        tag = "idle_after_reset";
        expect_n(6, 1'b0, 16'd0, 1'b0, 2'd0);
        drain(6);

        // Single wall note
        tag = "wall";
        ev_wall = 1'b1;
        expect_n(1,  1'b0, 16'd0,     1'b0, 2'd0);
        expect_n(NT, 1'b1, 16'd17026, 1'b1, 2'd0);
        expect_n(3,  1'b0, 16'd0,     1'b0, 2'd0);
        drain(exp_q.size());

        // Brick: two notes with a gap holding the first period
        tag = "brick";
        ev_brick = 1'b1;
        expect_n(1,  1'b0, 16'd0,     1'b0, 2'd0);
        expect_n(NT, 1'b1, 16'd11364, 1'b1, 2'd2);
        expect_n(GT, 1'b0, 16'd11364, 1'b1, 2'd2);
        expect_n(NT, 1'b1, 16'd8513,  1'b1, 2'd2);
        expect_n(3,  1'b0, 16'd0,     1'b0, 2'd2);
        drain(exp_q.size());

        // Wall and paddle together: paddle first, one idle cycle, then wall
        tag = "wall_paddle_prio";
        ev_wall   = 1'b1;
        ev_paddle = 1'b1;
        expect_n(1,  1'b0, 16'd0,     1'b0, 2'd2);
        expect_n(NT, 1'b1, 16'd12755, 1'b1, 2'd1);
        expect_n(1,  1'b0, 16'd0,     1'b0, 2'd1);
        expect_n(NT, 1'b1, 16'd17026, 1'b1, 2'd0);
        expect_n(3,  1'b0, 16'd0,     1'b0, 2'd0);
        drain(exp_q.size());

        // Lose preempts brick 8 cycles into its first note; brick not resumed
        tag = "lose_preempt";
        ev_brick = 1'b1;
        expect_n(1, 1'b0, 16'd0,     1'b0, 2'd0);
        expect_n(8, 1'b1, 16'd11364, 1'b1, 2'd2);
        drain(9);
        ev_lose = 1'b1;
        expect_n(1, 1'b1, 16'd11364, 1'b1, 2'd2);
        expect_lose();
        expect_n(10, 1'b0, 16'd0, 1'b0, 2'd3);
        drain(exp_q.size());

        // Lose during lose playback replays after one idle cycle
        tag = "lose_replay";
        ev_lose = 1'b1;
        expect_n(1, 1'b0, 16'd0, 1'b0, 2'd3);
        expect_lose();
        expect_n(1, 1'b0, 16'd0, 1'b0, 2'd3);
        expect_lose();
        expect_n(3, 1'b0, 16'd0, 1'b0, 2'd3);
        drain(4);
        ev_lose = 1'b1;
        drain(exp_q.size());

        // Mute mid-lose with paddle pending: silence and empty queue
        tag = "mute";
        ev_lose = 1'b1;
        expect_n(1, 1'b0, 16'd0, 1'b0, 2'd3);
        drain(1);
        ev_paddle = 1'b1;
        expect_n(5, 1'b1, 16'd17026, 1'b1, 2'd3);
        drain(5);
        mute    = 1'b1;
        ev_wall = 1'b1;
        expect_n(5, 1'b0, 16'd0, 1'b0, 2'd3);
        drain(5);
        tag  = "mute_release";
        mute = 1'b0;
        expect_n(12, 1'b0, 16'd0, 1'b0, 2'd3);
        drain(12);

        // Reset during a gap, then a normal paddle sequence
        tag = "rst_in_gap";
        ev_brick = 1'b1;
        expect_n(1,  1'b0, 16'd0,     1'b0, 2'd3);
        expect_n(NT, 1'b1, 16'd11364, 1'b1, 2'd2);
        expect_n(2,  1'b0, 16'd11364, 1'b1, 2'd2);
        drain(exp_q.size());
        rst = 1'b1;
        expect_n(1, 1'b0, 16'd0, 1'b0, 2'd0);
        drain(1);
        rst = 1'b0;
        expect_n(2, 1'b0, 16'd0, 1'b0, 2'd0);
        drain(2);
        tag = "paddle_after_rst";
        ev_paddle = 1'b1;
        expect_n(1,  1'b0, 16'd0,     1'b0, 2'd0);
        expect_n(NT, 1'b1, 16'd12755, 1'b1, 2'd1);
        expect_n(3,  1'b0, 16'd0,     1'b0, 2'd1);
        drain(exp_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
